axi_lite_reg_slave: RTL

- AXI-Lite responder (slave end) backing a bank of NUM_REGS software-visible registers, each DATA_WIDTH wide.
- Accepts AW/W/AR from an interconnect or master, performs strobed writes and registered reads, and returns B/R responses.
- Register contents and per-register write pulses are exported to the surrounding peripheral logic.

---
 rtl/axi_common.sv | 16 +
 rtl/axi_lite_reg_slave_if.sv | 48 ++++
 rtl/axi_lite_wr_join.sv | 91 +++++++++
 rtl/axi_lite_reg_slave.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/axi_common.sv
// Shared AXI-Lite types and response codes used by the register slave,
// its write joiner and the bus interface.
package axi_common;

  typedef logic [2:0] prot_t;
  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  // AxPROT[1] set marks a non-secure access.
  function automatic logic prot_nonsecure(input prot_t prot);
    return prot[1];
  endfunction

endpackage

// File: rtl/axi_lite_reg_slave_if.sv
// AXI-Lite bus bundle (AW/W/B/AR/R) with master and slave views.
interface axi_lite_reg_slave_if #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64
);
  import axi_common::*;

  logic [ADDR_WIDTH-1:0]   aw_addr;
  prot_t                   aw_prot;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;

  resp_t                   b_resp;
  logic                    b_valid;
  logic                    b_ready;

  logic [ADDR_WIDTH-1:0]   ar_addr;
  prot_t                   ar_prot;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [DATA_WIDTH-1:0]   r_data;
  resp_t                   r_resp;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_addr, aw_prot, aw_valid, input  aw_ready,
    output w_data, w_strb, w_valid,    input  w_ready,
    input  b_resp, b_valid,            output b_ready,
    output ar_addr, ar_prot, ar_valid, input  ar_ready,
    input  r_data, r_resp, r_valid,    output r_ready
  );

  modport slave (
    input  aw_addr, aw_prot, aw_valid, output aw_ready,
    input  w_data, w_strb, w_valid,    output w_ready,
    output b_resp, b_valid,            input  b_ready,
    input  ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid,    input  r_ready
  );

endinterface

// File: rtl/axi_lite_wr_join.sv
// Write-channel joiner: captures AW and W independently (either order or
// together), then raises a one-cycle commit once both are held. New
// transfers are refused while the B response is still outstanding.
module axi_lite_wr_join
  import axi_common::*;
#(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
  input  prot_t                   aw_prot_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  input  logic [DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  input  logic                    stall_i,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output prot_t                   prot_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [DATA_WIDTH/8-1:0] strb_o,
  output logic                    commit_o
);

  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  prot_t                   prot_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH/8-1:0] strb_q;
  logic                    aw_fire;
  logic                    w_fire;

  assign aw_ready_o = !aw_held_q && !stall_i;
  assign w_ready_o  = !w_held_q && !stall_i;
  assign aw_fire    = aw_valid_i && aw_ready_o;
  assign w_fire     = w_valid_i && w_ready_o;
  assign commit_o   = aw_held_q && w_held_q;

  // Held flags: set on handshake, both dropped on commit.
  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    if (commit_o) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end else begin
      if (aw_fire) aw_held_d = 1'b1;
      if (w_fire)  w_held_d  = 1'b1;
    end
  end

  // Flag state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
    end
  end

  // Address/data holding registers, loaded on their own handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      prot_q <= '0;
      data_q <= '0;
      strb_q <= '0;
    end else begin
      if (aw_fire) begin
        addr_q <= aw_addr_i;
        prot_q <= aw_prot_i;
      end
      if (w_fire) begin
        data_q <= w_data_i;
        strb_q <= w_strb_i;
      end
    end
  end

  assign addr_o = addr_q;
  assign prot_o = prot_q;
  assign data_o = data_q;
  assign strb_o = strb_q;

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite register bank slave: NUM_REGS registers of DATA_WIDTH bits with
// byte-strobed writes, registered reads and per-register write pulses.
// Optional build macro AXI_LITE_REG_SLAVE_PROT_CHECK_EN rejects non-secure
// (prot[1]=1) accesses with SLVERR; without it prot is ignored.
module axi_lite_reg_slave
  import axi_common::*;
#(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  axi_lite_reg_slave_if.slave            bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
    $fatal(1, "axi_lite_reg_slave: DATA_WIDTH must be 32 or 64");
  end
  if (NUM_REGS < 1) begin : g_bad_num_regs
    $fatal(1, "axi_lite_reg_slave: NUM_REGS must be at least 1");
  end

  // ---------------- write path ----------------
  logic [ADDR_WIDTH-1:0] wr_addr;
  prot_t                 wr_prot;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic                  wr_commit;
  logic                  b_valid_q;
  resp_t                 b_resp_q;

  axi_lite_wr_join #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_join (
    .clk        (clk),
    .rst        (rst),
    .aw_addr_i  (bus.aw_addr),
    .aw_prot_i  (bus.aw_prot),
    .aw_valid_i (bus.aw_valid),
    .aw_ready_o (bus.aw_ready),
    .w_data_i   (bus.w_data),
    .w_strb_i   (bus.w_strb),
    .w_valid_i  (bus.w_valid),
    .w_ready_o  (bus.w_ready),
    .stall_i    (b_valid_q),
    .addr_o     (wr_addr),
    .prot_o     (wr_prot),
    .data_o     (wr_data),
    .strb_o     (wr_strb),
    .commit_o   (wr_commit)
  );

  logic [ADDR_WIDTH-1:0] wr_idx_full;
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_in_range;
  logic                  wr_prot_err;
  logic                  wr_ok;
  logic [NUM_REGS-1:0]   reg_wr_d;
  logic [NUM_REGS-1:0]   reg_wr_q;

  // Word index from the byte address; sub-word address bits are ignored.
  assign wr_idx_full = wr_addr >> ADDR_LSB;
  assign wr_idx      = wr_idx_full[IDX_W-1:0];
  assign wr_in_range = wr_idx_full < ADDR_WIDTH'(NUM_REGS);

  // ---------------- read path decode ----------------
  logic [ADDR_WIDTH-1:0] rd_idx_full;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_in_range;
  logic                  rd_prot_err;
  logic                  ar_fire;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  r_valid_q;
  logic [DATA_WIDTH-1:0] r_data_q;
  resp_t                 r_resp_q;

  assign rd_idx_full = bus.ar_addr >> ADDR_LSB;
  assign rd_idx      = rd_idx_full[IDX_W-1:0];
  assign rd_in_range = rd_idx_full < ADDR_WIDTH'(NUM_REGS);

`ifdef AXI_LITE_REG_SLAVE_PROT_CHECK_EN
  assign wr_prot_err = prot_nonsecure(wr_prot);
  assign rd_prot_err = prot_nonsecure(bus.ar_prot);
`else
  // prot is captured but has no effect in this build.
  logic unused_prot;
  assign unused_prot = ^{wr_prot, bus.ar_prot};
  assign wr_prot_err = 1'b0;
  assign rd_prot_err = 1'b0;
`endif

  assign wr_ok = wr_in_range && !wr_prot_err;

  // ---------------- register bank ----------------
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_WIDTH-1:0] data_q;

    assign reg_wr_d[gi] = wr_commit && wr_ok && (wr_idx == IDX_W'(gi));

    // Byte-strobed update of this register on an accepted commit.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_q <= '0;
      end else if (reg_wr_d[gi]) begin
        for (int k = 0; k < STRB_W; k++) begin
          if (wr_strb[k]) data_q[k*8 +: 8] <= wr_data[k*8 +: 8];
        end
      end
    end

    assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = data_q;
  end

  // Write pulses line up with the cycle the new value becomes visible.
  always_ff @(posedge clk) begin
    if (rst) reg_wr_q <= '0;
    else     reg_wr_q <= reg_wr_d;
  end

  assign reg_wr = reg_wr_q;

  // B channel: raised on commit, held with a stable response until b_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
    end else if (wr_commit) begin
      b_valid_q <= 1'b1;
      b_resp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (b_valid_q && bus.b_ready) begin
      b_valid_q <= 1'b0;
    end
  end

  assign bus.b_valid = b_valid_q;
  assign bus.b_resp  = b_resp_q;

  // ---------------- read path ----------------
  assign bus.ar_ready = !r_valid_q;
  assign ar_fire      = bus.ar_valid && !r_valid_q;

  // Read mux over the current (pre-commit) register contents.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_word = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // R channel: sample on AR handshake, hold data/resp stable until r_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else if (ar_fire) begin
      r_valid_q <= 1'b1;
      if (rd_in_range && !rd_prot_err) begin
        r_data_q <= rd_word;
        r_resp_q <= RESP_OKAY;
      end else begin
        r_data_q <= '0;
        r_resp_q <= RESP_SLVERR;
      end
    end else if (r_valid_q && bus.r_ready) begin
      r_valid_q <= 1'b0;
    end
  end

  assign bus.r_valid = r_valid_q;
  assign bus.r_data  = r_data_q;
  assign bus.r_resp  = r_resp_q;

endmodule
